// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Stall/flush sequencer for a 5-stage pipeline. Resolves load-use
//            hazards, taken branches, fetch wait, data-memory busy and
//            halt/resume into PC / IF-ID / ID-EX control, and keeps
//            saturating stall and flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUseRs1,
    input  logic                  idUseRs2,
    input  logic                  idexMemRead,
    input  logic [REG_ADDR_W-1:0] idexRd,
    input  logic                  branchTaken,
    input  logic                  imemReady,
    input  logic                  dmemBusy,
    input  logic                  haltReq,
    input  logic                  resume,
    output logic                  pcWrite,
    output logic                  ifidWrite,
    output logic                  ifidFlush,
    output logic                  idexFlush,
    output logic                  halted,
    output logic [CNT_W-1:0]      stallCount,
    output logic [CNT_W-1:0]      flushCount
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_STALL  = 2'd1;
    localparam logic [1:0] c_FREEZE = 2'd2;
    localparam logic [1:0] c_HALT   = 2'd3;

    // Action selected for the current cycle; both the next-state and the
    // output processes are keyed on it so their priorities can never diverge.
    localparam logic [2:0] c_ACT_NORMAL    = 3'd0;
    localparam logic [2:0] c_ACT_HALT      = 3'd1;
    localparam logic [2:0] c_ACT_FREEZE    = 3'd2;
    localparam logic [2:0] c_ACT_BRANCH    = 3'd3;
    localparam logic [2:0] c_ACT_LOADUSE   = 3'd4;
    localparam logic [2:0] c_ACT_STALLING  = 3'd5;
    localparam logic [2:0] c_ACT_FETCHWAIT = 3'd6;
    localparam logic [2:0] c_ACT_IDLE      = 3'd7;

    // The first bubble is inserted from RUN, the rest are counted in STALL.
    localparam logic [3:0]       c_STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam bit               c_MULTI_STALL  = (LOAD_STALL_CYCLES > 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             saved_stall_q, saved_stall_d;   // 1: FREEZE returns to STALL
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic             w_load_use;
    logic [1:0]       w_eval_state;
    logic [2:0]       w_action;

    // Load-use: EX holds a load whose nonzero destination feeds a source
    // register actually read by the instruction in ID.
    assign w_load_use = idexMemRead && (idexRd != '0) &&
                        ((idUseRs1 && (idexRd == idRs1)) ||
                         (idUseRs2 && (idexRd == idRs2)));

    // When FREEZE releases, this same cycle is judged by the saved state's
    // rules so that no dead cycle is added after the memory becomes free.
    assign w_eval_state = ((state_q == c_FREEZE) && !dmemBusy)
                        ? (saved_stall_q ? c_STALL : c_RUN)
                        : state_q;

    // Select the single action that applies this cycle, in priority order.
    always_comb begin
        w_action = c_ACT_IDLE;
        case (w_eval_state)
            c_RUN: begin
                if (haltReq)           w_action = c_ACT_HALT;
                else if (dmemBusy)     w_action = c_ACT_FREEZE;
                else if (branchTaken)  w_action = c_ACT_BRANCH;
                else if (w_load_use)   w_action = c_ACT_LOADUSE;
                else if (!imemReady)   w_action = c_ACT_FETCHWAIT;
                else                   w_action = c_ACT_NORMAL;
            end
            c_STALL: begin
                if (haltReq)           w_action = c_ACT_HALT;
                else if (dmemBusy)     w_action = c_ACT_FREEZE;
                else if (branchTaken)  w_action = c_ACT_BRANCH;
                else                   w_action = c_ACT_STALLING;
            end
            default:                   w_action = c_ACT_IDLE;   // FREEZE busy, HALT
        endcase
    end

    // State, bubble counter, saved state and performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= c_RUN;
            cnt_q         <= '0;
            saved_stall_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            saved_stall_q <= saved_stall_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Next state, bubble down-counter and the state remembered across FREEZE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        saved_stall_d = saved_stall_q;
        case (w_action)
            c_ACT_HALT: begin
                state_d = c_HALT;
            end
            c_ACT_FREEZE: begin
                state_d       = c_FREEZE;
                saved_stall_d = (w_eval_state == c_STALL);
            end
            c_ACT_BRANCH: begin
                state_d = c_RUN;
            end
            c_ACT_LOADUSE: begin
                if (c_MULTI_STALL) begin
                    cnt_d   = c_STALL_RELOAD;
                    state_d = c_STALL;
                end else begin
                    state_d = c_RUN;
                end
            end
            c_ACT_STALLING: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? c_RUN : c_STALL;
            end
            c_ACT_IDLE: begin
                if (state_q == c_HALT) begin
                    state_d = resume ? c_RUN : c_HALT;
                end else begin
                    state_d = c_FREEZE;
                end
            end
            default: begin
                state_d = c_RUN;
            end
        endcase
    end

    // Pipeline controls from the selected action; everything low in reset.
    always_comb begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        halted    = 1'b0;
        if (rst) begin
            halted = (state_q == c_HALT);
            case (w_action)
                c_ACT_NORMAL: begin
                    pcWrite   = 1'b1;
                    ifidWrite = 1'b1;
                end
                c_ACT_BRANCH: begin
                    pcWrite   = 1'b1;
                    ifidWrite = 1'b1;
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end
                c_ACT_LOADUSE, c_ACT_STALLING: begin
                    idexFlush = 1'b1;
                end
                c_ACT_FETCHWAIT: begin
                    ifidWrite = 1'b1;
                    ifidFlush = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating stall / flush event counters.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pcWrite && (state_q != c_HALT) && (stall_count_q != c_CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if ((w_action == c_ACT_BRANCH) && (flush_count_q != c_CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Brief    : Scoreboard bench for pipeline_hazard_controller. Three instances
//            (LOAD_STALL_CYCLES 2/3/1, CNT_W 16/16/2) share one stimulus bus;
//            each vector names the instance it expects a response from.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    typedef struct {
        int         dut;
        string      nm;
        logic [4:0] ctl;    // {pcWrite, ifidWrite, ifidFlush, idexFlush, halted}
        int         sc;
        int         fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] idRs1, idRs2, idexRd;
    logic       idUseRs1, idUseRs2, idexMemRead, branchTaken;
    logic       imemReady, dmemBusy, haltReq, resume;

    logic        pc0, iw0, iff0, idf0, h0;
    logic        pc1, iw1, iff1, idf1, h1;
    logic        pc2, iw2, iff2, idf2, h2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .idRs1(idRs1), .idRs2(idRs2), .idUseRs1(idUseRs1),
        .idUseRs2(idUseRs2), .idexMemRead(idexMemRead), .idexRd(idexRd),
        .branchTaken(branchTaken), .imemReady(imemReady), .dmemBusy(dmemBusy),
        .haltReq(haltReq), .resume(resume), .pcWrite(pc0), .ifidWrite(iw0),
        .ifidFlush(iff0), .idexFlush(idf0), .halted(h0), .stallCount(sc0), .flushCount(fc0));

    pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .idRs1(idRs1), .idRs2(idRs2), .idUseRs1(idUseRs1),
        .idUseRs2(idUseRs2), .idexMemRead(idexMemRead), .idexRd(idexRd),
        .branchTaken(branchTaken), .imemReady(imemReady), .dmemBusy(dmemBusy),
        .haltReq(haltReq), .resume(resume), .pcWrite(pc1), .ifidWrite(iw1),
        .ifidFlush(iff1), .idexFlush(idf1), .halted(h1), .stallCount(sc1), .flushCount(fc1));

    pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .idRs1(idRs1), .idRs2(idRs2), .idUseRs1(idUseRs1),
        .idUseRs2(idUseRs2), .idexMemRead(idexMemRead), .idexRd(idexRd),
        .branchTaken(branchTaken), .imemReady(imemReady), .dmemBusy(dmemBusy),
        .haltReq(haltReq), .resume(resume), .pcWrite(pc2), .ifidWrite(iw2),
        .ifidFlush(iff2), .idexFlush(idf2), .halted(h2), .stallCount(sc2), .flushCount(fc2));

    // Monitor: one response per cycle, compared mid-cycle against the queue.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [4:0] a_ctl;
            int         a_sc;
            int         a_fc;
            e = sb.pop_front();
            case (e.dut)
                0:       begin a_ctl = {pc0, iw0, iff0, idf0, h0}; a_sc = int'(sc0); a_fc = int'(fc0); end
                1:       begin a_ctl = {pc1, iw1, iff1, idf1, h1}; a_sc = int'(sc1); a_fc = int'(fc1); end
                default: begin a_ctl = {pc2, iw2, iff2, idf2, h2}; a_sc = int'(sc2); a_fc = int'(fc2); end
            endcase
            checks++;
            if (a_ctl !== e.ctl || a_sc != e.sc || a_fc != e.fc) begin
                errors++;
                $display("FAIL %s (dut%0d): got ctl=%b sc=%0d fc=%0d, expected ctl=%b sc=%0d fc=%0d",
                         e.nm, e.dut, a_ctl, a_sc, a_fc, e.ctl, e.sc, e.fc);
            end
        end
    end

    task automatic clean();
        idRs1 = '0; idRs2 = '0; idexRd = '0;
        idUseRs1 = 1'b0; idUseRs2 = 1'b0; idexMemRead = 1'b0;
        branchTaken = 1'b0; imemReady = 1'b1; dmemBusy = 1'b0;
        haltReq = 1'b0; resume = 1'b0;
    endtask

    // Push the expected response for the inputs now applied, then advance.
    task automatic step(input int d, input string nm, input logic [4:0] ctl,
                        input int sc, input int fc);
        exp_t e;
        e.dut = d; e.nm = nm; e.ctl = ctl; e.sc = sc; e.fc = fc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset with busy-looking inputs, expect all controls low, then release.
    task automatic do_reset(input int d);
        rst = 1'b0;
        branchTaken = 1'b1; imemReady = 1'b0; idexMemRead = 1'b1;
        idexRd = 5'd7; idRs1 = 5'd7; idUseRs1 = 1'b1;
        step(d, "reset", 5'b00000, 0, 0);
        clean();
        rst = 1'b1;
    endtask

    initial begin
        clean();
        @(posedge clk);
        #1;

        // Reset and release
        do_reset(0);
        step(0, "reset_release", 5'b11000, 0, 0);
        step(0, "run_idle",      5'b11000, 0, 0);

        // Load-use with two bubble cycles
        do_reset(0);
        step(0, "lu2_pre", 5'b11000, 0, 0);
        idexMemRead = 1'b1; idexRd = 5'd5; idRs2 = 5'd5; idUseRs2 = 1'b1;
        step(0, "lu2_stall1", 5'b00010, 0, 0);
        step(0, "lu2_stall2", 5'b00010, 1, 0);
        clean();
        step(0, "lu2_resume", 5'b11000, 2, 0);

        // Branch beats a simultaneous load-use
        do_reset(0);
        branchTaken = 1'b1; idexMemRead = 1'b1; idexRd = 5'd3; idRs1 = 5'd3; idUseRs1 = 1'b1;
        step(0, "br_vs_lu", 5'b11110, 0, 0);
        clean();
        step(0, "br_after", 5'b11000, 0, 1);

        // dmemBusy in the middle of a 3-cycle stall
        do_reset(1);
        step(1, "fz_pre", 5'b11000, 0, 0);
        idexMemRead = 1'b1; idexRd = 5'd9; idRs1 = 5'd9; idUseRs1 = 1'b1;
        step(1, "fz_stall1", 5'b00010, 0, 0);
        clean();
        dmemBusy = 1'b1;
        step(1, "fz_busy1", 5'b00000, 1, 0);
        step(1, "fz_busy2", 5'b00000, 2, 0);
        step(1, "fz_busy3", 5'b00000, 3, 0);
        step(1, "fz_busy4", 5'b00000, 4, 0);
        dmemBusy = 1'b0;
        step(1, "fz_stall2", 5'b00010, 5, 0);
        step(1, "fz_stall3", 5'b00010, 6, 0);
        step(1, "fz_done",   5'b11000, 7, 0);

        // Fetch wait
        do_reset(0);
        step(0, "iw_pre", 5'b11000, 0, 0);
        imemReady = 1'b0;
        step(0, "iw_wait1", 5'b01100, 0, 0);
        step(0, "iw_wait2", 5'b01100, 1, 0);
        step(0, "iw_wait3", 5'b01100, 2, 0);
        clean();
        step(0, "iw_done", 5'b11000, 3, 0);

        // Halt / resume, held halt with resume, halt deferred by FREEZE
        do_reset(0);
        step(0, "h_pre", 5'b11000, 0, 0);
        haltReq = 1'b1;
        step(0, "h_req", 5'b00000, 0, 0);
        haltReq = 1'b0;
        step(0, "h_halted1", 5'b00001, 1, 0);
        step(0, "h_halted2", 5'b00001, 1, 0);
        resume = 1'b1;
        step(0, "h_resume", 5'b00001, 1, 0);
        clean();
        step(0, "h_run", 5'b11000, 1, 0);
        haltReq = 1'b1;
        step(0, "hh_req", 5'b00000, 1, 0);
        resume = 1'b1;
        step(0, "hh_resume", 5'b00001, 2, 0);
        resume = 1'b0;
        step(0, "hh_rehalt", 5'b00000, 2, 0);
        haltReq = 1'b0;
        step(0, "hh_halted", 5'b00001, 3, 0);
        resume = 1'b1;
        step(0, "hh_resume2", 5'b00001, 3, 0);
        clean();
        step(0, "hh_run", 5'b11000, 3, 0);
        dmemBusy = 1'b1;
        step(0, "fh_busy", 5'b00000, 3, 0);
        haltReq = 1'b1;
        step(0, "fh_deferred", 5'b00000, 4, 0);
        dmemBusy = 1'b0;
        step(0, "fh_halt", 5'b00000, 5, 0);
        haltReq = 1'b0;
        step(0, "fh_halted", 5'b00001, 6, 0);
        resume = 1'b1;
        step(0, "fh_resume", 5'b00001, 6, 0);
        clean();
        step(0, "fh_run", 5'b11000, 6, 0);

        // Saturation with CNT_W=2, rd=0 filter, single-cycle load-use
        do_reset(2);
        imemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(2, "sat_stall", 5'b01100, (i < 3) ? i : 3, 0);
        end
        clean();
        step(2, "sat_hold", 5'b11000, 3, 0);
        idexMemRead = 1'b1; idexRd = 5'd0; idRs1 = 5'd0; idUseRs1 = 1'b1;
        step(2, "rd0_nostall", 5'b11000, 3, 0);
        idexRd = 5'd4; idRs1 = 5'd4;
        step(2, "lu1_stall", 5'b00010, 3, 0);
        clean();
        step(2, "lu1_resume", 5'b11000, 3, 0);
        branchTaken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(2, "sat_flush", 5'b11110, 3, i);
        end
        clean();
        step(2, "sat_flush_hold", 5'b11000, 3, 3);

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives PC write enable, IF/ID write enable and flush, and the ID/EX bubble insert, from:
  - load-use hazards
  - taken branches resolved in EX
  - instruction-fetch wait
  - data-memory busy
  - halt/resume requests
- Keeps saturating stall and flush performance counters.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (legal 1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- idRs1  in  REG_ADDR_W  rs1 of the instruction in ID.
- idRs2  in  REG_ADDR_W  rs2 of the instruction in ID.
- idUseRs1  in  1  ID instruction reads rs1.
- idUseRs2  in  1  ID instruction reads rs2.
- idexMemRead  in  1  instruction in EX is a load.
- idexRd  in  REG_ADDR_W  destination of the instruction in EX.
- branchTaken  in  1  EX resolved a taken branch or jump this cycle.
- imemReady  in  1  fetch data valid this cycle.
- dmemBusy  in  1  data memory is not accepting/returning this cycle.
- haltReq  in  1  request to halt (level).
- resume  in  1  leave HALT (pulse).
- pcWrite  out  1  PC update enable.
- ifidWrite  out  1  IF/ID writeEnable.
- ifidFlush  out  1  load NOP into IF/ID.
- idexFlush  out  1  load bubble into ID/EX.
- halted  out  1  controller in HALT.
- stallCount  out  CNT_W  cycles with pcWrite=0 outside HALT.
- flushCount  out  CNT_W  branch flush events.

Behaviour:

Reset (rst=0, asynchronous):
- State=RUN; stall counter=0; stallCount=flushCount=0; saved state=RUN.
- While rst=0, all control outputs are forced 0 and halted=0.

Outputs are combinational (same cycle) from the current state and inputs. The state, down-counter and perf counters update on the rising edge of clk.

loadUse = idexMemRead & (idexRd!=0) & ((idUseRs1 & idexRd==idRs1) | (idUseRs2 & idexRd==idRs2)).

States: RUN, STALL, FREEZE, HALT.

RUN. Inputs are evaluated in priority order; the first match applies:
1. haltReq: all controls 0; next=HALT.
2. dmemBusy: all controls 0; save RUN; next=FREEZE.
3. branchTaken:
   - pcWrite=1, ifidWrite=1, ifidFlush=1, idexFlush=1.
   - flushCount+1; stays RUN.
   - A simultaneous loadUse is ignored.
4. loadUse:
   - pcWrite=0, ifidWrite=0, idexFlush=1.
   - If LOAD_STALL_CYCLES>1: load counter with LOAD_STALL_CYCLES-1; next=STALL.
5. !imemReady: pcWrite=0, ifidWrite=1, ifidFlush=1 (NOP into ID).
6. Otherwise: pcWrite=1, ifidWrite=1, flushes 0.

STALL:
- Priority: haltReq > dmemBusy > branchTaken.
  - haltReq: next=HALT; the remaining counter is discarded.
  - dmemBusy: all controls 0; save STALL; counter holds; next=FREEZE.
  - branchTaken: same outputs as RUN rule 3; stall abandoned; next=RUN.
- Otherwise: pcWrite=0, ifidWrite=0, idexFlush=1; counter-1.
- Next=RUN in the cycle the counter reads 1.

FREEZE:
- All controls 0 while dmemBusy=1.
- The first cycle dmemBusy=0 is evaluated with the rules of the saved state (Mealy, no extra dead cycle).
- haltReq in FREEZE is deferred until dmemBusy=0.

HALT:
- All controls 0; halted=1.
- On resume=1: next=RUN.
- haltReq held high together with resume: resume wins for one cycle; RUN rule 1 then re-enters HALT.

Counters:
- stallCount+1 on every clock where pcWrite=0 and state!=HALT and rst=1.
- flushCount+1 on every branch flush.
- Both saturate at 2^CNT_W-1 and never wrap.

Load-use with idexRd=0 never stalls.

Test Plan:
- Reset: rst=0 with arbitrary inputs → all control outputs 0, counters 0; release with clean inputs → pcWrite=ifidWrite=1 on the first edge.
- Load-use, LOAD_STALL_CYCLES=2: idexMemRead=1, idexRd=5, idRs2=5, idUseRs2=1 → exactly 2 cycles of pcWrite=0, ifidWrite=0, idexFlush=1, then RUN; stallCount=2.
- Branch vs load-use in the same cycle: branchTaken=1 with loadUse=1 → ifidFlush=idexFlush=1, pcWrite=1, no stall; flushCount=1.
- dmemBusy mid-STALL (LOAD_STALL_CYCLES=3): assert after the 1st stall cycle for 4 cycles → controls 0 for those 4 cycles, then 2 more stall cycles; stallCount=7.
- imemReady=0 for 3 cycles → pcWrite=0, ifidFlush=1, ifidWrite=1 each cycle; stallCount=3; no idexFlush.
- Halt/resume plus saturation:
  - haltReq pulse → halted=1, stallCount frozen.
  - resume pulse → RUN next cycle.
  - CNT_W=2 with 5 stall cycles → stallCount=3.
